// File: rtl/raifes_jtag_dtm.sv
// raifes_jtag_dtm: oversampled JTAG TAP controller plus RISC-V Debug Transport
// Module (debug spec 0.13). TCK/TMS/TDI are sampled on clk, so there is one
// clock domain. The JTAG side feeds DMI requests to the debug module.
// Optional feature macro: RAIFES_JTAG_IDCODE_EN. When it is defined, the IDCODE
// instruction (0x01) and its register exist and IR resets to 0x01. Otherwise
// 0x01 decodes as BYPASS and IR resets to 0x1F.
module raifes_jtag_dtm #(
    parameter logic [31:0] IDCODE = 32'h1000_0A6D,
    parameter int unsigned ABITS  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tck,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [1:0]       dmi_req_op,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    input  logic             dmi_resp_valid,
    input  logic [31:0]      dmi_resp_data,
    input  logic             dmi_resp_err
);

    localparam int DW = ABITS + 34;
    localparam logic [5:0] ABITS_F = 6'(ABITS);

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
`ifdef RAIFES_JTAG_IDCODE_EN
    localparam logic [4:0]  IR_RESET   = 5'h01;
    localparam logic [31:0] IDCODE_VAL = IDCODE;
`else
    localparam logic [4:0]  IR_RESET   = 5'h1F;
    localparam logic [31:0] IDCODE_VAL = 32'h0000_0000;
`endif

    typedef enum logic [3:0] {
        TAP_RESET, TAP_IDLE,
        TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR, TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPDATE_DR,
        TAP_SEL_IR, TAP_CAP_IR, TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPDATE_IR
    } tap_state_e;

    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_BUSY = 2'd1,
        REQ_WAIT = 2'd2
    } req_state_e;

    // IEEE 1149.1 TAP transition table.
    function automatic tap_state_e tap_next(input tap_state_e s, input logic m);
        tap_state_e n;
        case (s)
            TAP_RESET:     n = m ? TAP_RESET    : TAP_IDLE;
            TAP_IDLE:      n = m ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_DR:    n = m ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:    n = m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR:  n = m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR:  n = m ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:  n = m ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR:  n = m ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR: n = m ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_IR:    n = m ? TAP_RESET    : TAP_CAP_IR;
            TAP_CAP_IR:    n = m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR:  n = m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR:  n = m ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:  n = m ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR:  n = m ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR: n = m ? TAP_SEL_DR   : TAP_IDLE;
            default:       n = TAP_RESET;
        endcase
        return n;
    endfunction

    // Sticky status only ever moves up; a lower error code never hides a higher one.
    function automatic logic [1:0] stat_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic tck_s1_q, tck_s2_q, tck_s3_q, tms_s1_q, tms_s2_q, tdi_s1_q, tdi_s2_q;
    logic tck_s1_d, tck_s2_d, tck_s3_d, tms_s1_d, tms_s2_d, tdi_s1_d, tdi_s2_d;
    logic tck_rise_s, tck_fall_s;

    tap_state_e tap_q, tap_d;
    logic [4:0]    ir_q, ir_d, ir_shift_q, ir_shift_d;
    logic [DW-1:0] dr_q, dr_d, tdi_mask_s;
    logic [7:0]    dr_msb_s;
    logic          tdo_q, tdo_d;
    logic          sel_idcode_s, sel_dtmcs_s, sel_dmi_s;

    req_state_e    req_state_q, req_state_d;
    logic          req_valid_q, req_valid_d;
    logic [1:0]    req_op_q, req_op_d;
    logic [ABITS-1:0] req_addr_q, req_addr_d;
    logic [31:0]   req_data_q, req_data_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic [1:0]    sticky_q, sticky_d;
    logic          busy_s, op_ok_s;

    // Two-flop synchronisers on the raw pins plus a third tck stage for edge detection.
    always_comb begin
        tck_s1_d   = tck;
        tck_s2_d   = tck_s1_q;
        tck_s3_d   = tck_s2_q;
        tms_s1_d   = tms;
        tms_s2_d   = tms_s1_q;
        tdi_s1_d   = tdi;
        tdi_s2_d   = tdi_s1_q;
        tck_rise_s = tck_s2_q & ~tck_s3_q;
        tck_fall_s = ~tck_s2_q & tck_s3_q;
    end

    // TAP state advances on each synchronised tck rising edge.
    always_comb begin
        if (tck_rise_s) begin
            tap_d = tap_next(tap_q, tms_s2_q);
        end else begin
            tap_d = tap_q;
        end
    end

    // Instruction decode and the active DR length (MSB position for the incoming tdi bit).
    always_comb begin
`ifdef RAIFES_JTAG_IDCODE_EN
        sel_idcode_s = (ir_q == IR_IDCODE);
`else
        sel_idcode_s = 1'b0;
`endif
        sel_dtmcs_s = (ir_q == IR_DTMCS);
        sel_dmi_s   = (ir_q == IR_DMI);
        if (sel_dmi_s) begin
            dr_msb_s = 8'(DW - 1);
        end else if (sel_dtmcs_s || sel_idcode_s) begin
            dr_msb_s = 8'd31;
        end else begin
            dr_msb_s = 8'd0;
        end
        tdi_mask_s = {{(DW-1){1'b0}}, 1'b1} << dr_msb_s;
    end

    // IR/DR capture-shift-update, tdo drive, and the DMI request/response tracker.
    always_comb begin
        ir_shift_d  = ir_shift_q;
        dr_d        = dr_q;
        tdo_d       = tdo_q;
        req_state_d = req_state_q;
        req_op_d    = req_op_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        resp_data_d = resp_data_q;
        sticky_d    = sticky_q;
        op_ok_s     = (dr_q[1:0] == 2'd1) || (dr_q[1:0] == 2'd2);

        if (tap_q == TAP_RESET) begin
            ir_d = IR_RESET;
        end else begin
            ir_d = ir_q;
        end

        // Debug-module side first, so a same-cycle response retires before a new Update-DR.
        case (req_state_q)
            REQ_BUSY: begin
                if (dmi_req_ready) begin
                    req_state_d = REQ_WAIT;
                end else begin
                    req_state_d = REQ_BUSY;
                end
            end
            REQ_WAIT: begin
                if (dmi_resp_valid) begin
                    req_state_d = REQ_IDLE;
                    resp_data_d = dmi_resp_data;
                    if (dmi_resp_err) begin
                        sticky_d = stat_max(sticky_d, 2'd2);
                    end else begin
                        sticky_d = sticky_d;
                    end
                end else begin
                    req_state_d = REQ_WAIT;
                end
            end
            default: req_state_d = req_state_q;
        endcase
        busy_s = (req_state_d != REQ_IDLE);

        if (tck_rise_s) begin
            case (tap_q)
                TAP_CAP_IR:    ir_shift_d = 5'b00001;
                TAP_SHIFT_IR:  ir_shift_d = {tdi_s2_q, ir_shift_q[4:1]};
                TAP_UPDATE_IR: ir_d = ir_shift_q;
                TAP_CAP_DR: begin
                    if (sel_dmi_s) begin
                        dr_d = {req_addr_q, resp_data_d, (busy_s ? 2'd3 : sticky_d)};
                        if (busy_s) begin
                            sticky_d = stat_max(sticky_d, 2'd3);
                        end else begin
                            sticky_d = sticky_d;
                        end
                    end else if (sel_dtmcs_s) begin
                        dr_d = DW'({17'd0, 3'd1, sticky_d, ABITS_F, 4'd1});
                    end else if (sel_idcode_s) begin
                        dr_d = DW'(IDCODE_VAL);
                    end else begin
                        dr_d = {DW{1'b0}};
                    end
                end
                TAP_SHIFT_DR:  dr_d = (dr_q >> 1) | ({DW{tdi_s2_q}} & tdi_mask_s);
                TAP_UPDATE_DR: begin
                    if (sel_dmi_s) begin
                        if (sticky_d != 2'd0) begin
                            sticky_d = sticky_d;
                        end else if (busy_s) begin
                            sticky_d = 2'd3;
                        end else if (op_ok_s) begin
                            req_state_d = REQ_BUSY;
                            req_op_d    = dr_q[1:0];
                            req_data_d  = dr_q[33:2];
                            req_addr_d  = dr_q[DW-1:34];
                        end else begin
                            req_state_d = req_state_d;
                        end
                    end else if (sel_dtmcs_s) begin
                        if (dr_q[17]) begin
                            sticky_d    = 2'd0;
                            req_state_d = REQ_IDLE;
                        end else if (dr_q[16]) begin
                            sticky_d = 2'd0;
                        end else begin
                            sticky_d = sticky_d;
                        end
                    end else begin
                        dr_d = dr_q;
                    end
                end
                default: dr_d = dr_q;
            endcase
        end else begin
            dr_d = dr_q;
        end

        if (tck_fall_s) begin
            case (tap_q)
                TAP_SHIFT_DR: tdo_d = dr_q[0];
                TAP_SHIFT_IR: tdo_d = ir_shift_q[0];
                default:      tdo_d = 1'b0;
            endcase
        end else begin
            tdo_d = tdo_q;
        end

        req_valid_d = (req_state_d == REQ_BUSY);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            tck_s1_q    <= 1'b0;
            tck_s2_q    <= 1'b0;
            tck_s3_q    <= 1'b0;
            tms_s1_q    <= 1'b0;
            tms_s2_q    <= 1'b0;
            tdi_s1_q    <= 1'b0;
            tdi_s2_q    <= 1'b0;
            tap_q       <= TAP_RESET;
            ir_q        <= IR_RESET;
            ir_shift_q  <= 5'd0;
            dr_q        <= {DW{1'b0}};
            tdo_q       <= 1'b0;
            req_state_q <= REQ_IDLE;
            req_valid_q <= 1'b0;
            req_op_q    <= 2'd0;
            req_addr_q  <= {ABITS{1'b0}};
            req_data_q  <= 32'd0;
            resp_data_q <= 32'd0;
            sticky_q    <= 2'd0;
        end else begin
            tck_s1_q    <= tck_s1_d;
            tck_s2_q    <= tck_s2_d;
            tck_s3_q    <= tck_s3_d;
            tms_s1_q    <= tms_s1_d;
            tms_s2_q    <= tms_s2_d;
            tdi_s1_q    <= tdi_s1_d;
            tdi_s2_q    <= tdi_s2_d;
            tap_q       <= tap_d;
            ir_q        <= ir_d;
            ir_shift_q  <= ir_shift_d;
            dr_q        <= dr_d;
            tdo_q       <= tdo_d;
            req_state_q <= req_state_d;
            req_valid_q <= req_valid_d;
            req_op_q    <= req_op_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            resp_data_q <= resp_data_d;
            sticky_q    <= sticky_d;
        end
    end

    assign tdo           = tdo_q;
    assign dmi_req_valid = req_valid_q;
    assign dmi_req_op    = req_op_q;
    assign dmi_req_addr  = req_addr_q;
    assign dmi_req_data  = req_data_q;

endmodule

// File: tb/tb_raifes_jtag_dtm.sv
// Testbench for raifes_jtag_dtm: bit-banged JTAG scans on an oversampled tck,
// a table of IR/DR vectors, hand-written DMI corner sequences, and randomized
// DMI traffic checked against a transaction-level model.
module tb_raifes_jtag_dtm;

    localparam int          ABITS = 6;
    localparam int          DW    = ABITS + 34;
    localparam logic [31:0] IDC   = 32'h1000_0A6D;

    logic clk = 1'b0;
    logic reset, tck, tms, tdi, tdo;
    logic dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_err;
    logic [1:0] dmi_req_op;
    logic [ABITS-1:0] dmi_req_addr;
    logic [31:0] dmi_req_data, dmi_resp_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    raifes_jtag_dtm #(.IDCODE(IDC), .ABITS(ABITS)) dut (
        .clk(clk), .reset(reset), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_op(dmi_req_op), .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_data(dmi_resp_data), .dmi_resp_err(dmi_resp_err)
    );

    typedef struct {
        logic [4:0]  ir;
        int          w;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dmi_word(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op);
        return {24'd0, a, d, op};
    endfunction

    // One TCK period of 8 clk: tdo sampled just before the rising edge.
    task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tms = tms_v;
        tdi = tdi_v;
        repeat (4) @(posedge clk);
        #1;
        tdo_v = tdo;
        tck = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tck = 1'b0;
    endtask

    task automatic tap_reset();
        logic o;
        repeat (5) tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
    endtask

    // Run-Test/Idle -> IR scan -> Run-Test/Idle.
    task automatic scan_ir(input logic [4:0] ir, output logic [4:0] cap);
        logic o;
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, ir[i], o);
            cap[i] = o;
        end
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
    endtask

    // Run-Test/Idle -> DR scan of w bits -> Run-Test/Idle (Update-DR on the last rise).
    task automatic scan_dr(input int w, input logic [63:0] din, output logic [63:0] dout);
        logic o;
        dout = 64'd0;
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
        for (int i = 0; i < w; i++) begin
            tck_cycle(i == w - 1, din[i], o);
            dout[i] = o;
        end
        tck_cycle(1'b1, 1'b0, o);
        tck_cycle(1'b0, 1'b0, o);
    endtask

    task automatic pulse_ready();
        dmi_req_ready = 1'b1;
        @(posedge clk);
        #1;
        dmi_req_ready = 1'b0;
    endtask

    task automatic pulse_resp(input logic [31:0] d, input logic e);
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = d;
        dmi_resp_err   = e;
        @(posedge clk);
        #1;
        dmi_resp_valid = 1'b0;
        dmi_resp_data  = 32'd0;
        dmi_resp_err   = 1'b0;
    endtask

    initial begin
        logic [4:0]  icap;
        logic [63:0] o, rin, exp_cap;
        logic        dummy;
        logic [5:0]  m_addr, ra;
        logic [31:0] m_data, rd;
        logic [1:0]  m_stick, rop;
        int          m_st;
        logic        acc, er;

        tck = 1'b0; tms = 1'b1; tdi = 1'b0;
        dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp_data = 32'd0; dmi_resp_err = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset tdo", tdo, 64'd0);
        check("reset valid", dmi_req_valid, 64'd0);
        check("reset op", dmi_req_op, 64'd0);
        check("reset addr", dmi_req_addr, 64'd0);
        check("reset data", dmi_req_data, 64'd0);

        // DR scan straight out of reset uses the reset instruction.
        tck_cycle(1'b0, 1'b0, dummy);
        rin = 64'($urandom);
        scan_dr(32, rin, o);
`ifdef RAIFES_JTAG_IDCODE_EN
        check("reset idcode", o, 64'(IDC));
`else
        check("reset bypass", o, (rin << 1) & 64'h0000_0000_FFFF_FFFF);
`endif
        repeat (4) @(posedge clk);
        #1;
        check("tdo idle", tdo, 64'd0);

        vecs[0] = '{5'h10, 32, 64'h0, 64'h1061};
`ifdef RAIFES_JTAG_IDCODE_EN
        vecs[1] = '{5'h01, 32, 64'h0, 64'(IDC)};
`else
        vecs[1] = '{5'h01, 8, 64'h5A, 64'hB4};
`endif
        vecs[2] = '{5'h1F, 8, 64'hA5, 64'h4A};
        vecs[3] = '{5'h00, 8, 64'h3C, 64'h78};
        vecs[4] = '{5'h11, DW, 64'h0, 64'h0};
        vecs[5] = '{5'h12, 4, 64'h9, 64'h2};
        vecs[6] = '{5'h10, 32, 64'hFFFF_FFFF, 64'h1061};
        for (int i = 0; i < 7; i++) begin
            scan_ir(vecs[i].ir, icap);
            check($sformatf("vec%0d ircap", i), icap, 64'h01);
            scan_dr(vecs[i].w, vecs[i].din, o);
            check($sformatf("vec%0d dr", i), o, vecs[i].exp);
        end

        // DMI write, held while not accepted, then completed.
        scan_ir(5'h11, icap);
        scan_dr(DW, dmi_word(6'h10, 32'h8000_0000, 2'd2), o);
        check("wr cap", o, 64'd0);
        check("wr valid", dmi_req_valid, 64'd1);
        check("wr addr", dmi_req_addr, 64'h10);
        check("wr data", dmi_req_data, 64'h8000_0000);
        check("wr op", dmi_req_op, 64'd2);
        repeat (5) @(posedge clk);
        #1;
        check("wr hold", {dmi_req_valid, dmi_req_addr, dmi_req_data}, {1'b1, 6'h10, 32'h8000_0000});
        pulse_ready();
        check("wr valid drop", dmi_req_valid, 64'd0);
        pulse_resp(32'h0, 1'b0);
        scan_dr(DW, dmi_word(6'h0, 32'h0, 2'd0), o);
        check("wr done cap", o, dmi_word(6'h10, 32'h0, 2'd0));

        // DMI read returns response data on the next capture.
        scan_dr(DW, dmi_word(6'h24, 32'h0, 2'd1), o);
        check("rd valid", {dmi_req_valid, dmi_req_op, dmi_req_addr}, {1'b1, 2'd1, 6'h24});
        pulse_ready();
        pulse_resp(32'hCAFE_0001, 1'b0);
        scan_dr(DW, dmi_word(6'h0, 32'h0, 2'd0), o);
        check("rd cap", o, dmi_word(6'h24, 32'hCAFE_0001, 2'd0));

        // Update-DR while busy: ignored, sticky busy, cleared by dmireset.
        scan_dr(DW, dmi_word(6'h05, 32'h0, 2'd1), o);
        check("busy1 valid", dmi_req_valid, 64'd1);
        pulse_ready();
        scan_dr(DW, dmi_word(6'h06, 32'h0, 2'd1), o);
        check("busy2 cap", o, dmi_word(6'h05, 32'hCAFE_0001, 2'd3));
        check("busy2 no req", dmi_req_valid, 64'd0);
        scan_dr(DW, dmi_word(6'h0, 32'h0, 2'd0), o);
        check("busy sticky cap", o, dmi_word(6'h05, 32'hCAFE_0001, 2'd3));
        pulse_resp(32'h1234_5678, 1'b0);
        scan_ir(5'h10, icap);
        scan_dr(32, 64'h0001_0000, o);
        check("dtmcs stat3", o, 64'h1C61);
        scan_dr(32, 64'h0, o);
        check("dtmcs cleared", o, 64'h1061);
        scan_ir(5'h11, icap);
        scan_dr(DW, dmi_word(6'h0, 32'h0, 2'd0), o);
        check("busy done cap", o, dmi_word(6'h05, 32'h1234_5678, 2'd0));

        // Error response: sticky 2 blocks requests, survives a TAP reset, cleared by dmireset.
        scan_dr(DW, dmi_word(6'h07, 32'hDEAD_BEEF, 2'd2), o);
        pulse_ready();
        pulse_resp(32'h0, 1'b1);
        scan_dr(DW, dmi_word(6'h0, 32'h0, 2'd0), o);
        check("err cap", o, dmi_word(6'h07, 32'h0, 2'd2));
        scan_dr(DW, dmi_word(6'h08, 32'h1, 2'd2), o);
        check("err blocked cap", o, dmi_word(6'h07, 32'h0, 2'd2));
        check("err blocked", dmi_req_valid, 64'd0);
        tap_reset();
        scan_ir(5'h10, icap);
        scan_dr(32, 64'h0001_0000, o);
        check("dtmcs stat2", o, 64'h1861);
        scan_ir(5'h11, icap);
        scan_dr(DW, dmi_word(6'h08, 32'h11, 2'd2), o);
        check("err cleared cap", o, dmi_word(6'h07, 32'h0, 2'd0));
        check("err cleared req", {dmi_req_valid, dmi_req_addr}, {1'b1, 6'h08});

        // System reset during a pending request drops it.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst mid valid", dmi_req_valid, 64'd0);
        check("rst mid outs", {dmi_req_op, dmi_req_addr, dmi_req_data}, 64'd0);
        tck_cycle(1'b0, 1'b0, dummy);

        // dmihardreset drops the request and discards its late response.
        scan_ir(5'h11, icap);
        scan_dr(DW, dmi_word(6'h09, 32'h0, 2'd1), o);
        check("hr cap", o, 64'd0);
        check("hr req", dmi_req_valid, 64'd1);
        scan_ir(5'h10, icap);
        scan_dr(32, 64'h0002_0000, o);
        check("hr dtmcs", o, 64'h1061);
        check("hr dropped", dmi_req_valid, 64'd0);
        pulse_resp(32'h0000_0BAD, 1'b1);
        scan_dr(32, 64'h0, o);
        check("hr resp ignored", o, 64'h1061);
        scan_ir(5'h11, icap);
        scan_dr(DW, dmi_word(6'h0, 32'h0, 2'd0), o);
        check("hr dmi cap", o, dmi_word(6'h09, 32'h0, 2'd0));

        // Randomized DMI traffic against a transaction-level model.
        m_addr = 6'h09; m_data = 32'h0; m_stick = 2'd0; m_st = 0;
        for (int it = 0; it < 24; it++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 6'($urandom);
            rd  = $urandom;
            exp_cap = dmi_word(m_addr, m_data, (m_st != 0) ? 2'd3 : m_stick);
            if (m_st != 0) m_stick = 2'd3;
            scan_dr(DW, dmi_word(ra, rd, rop), o);
            check($sformatf("rnd%0d cap", it), o, exp_cap);
            acc = (m_stick == 2'd0) && (m_st == 0) && (rop == 2'd1 || rop == 2'd2);
            if (acc) begin
                m_addr = ra;
                m_st = 1;
                check($sformatf("rnd%0d req", it), {dmi_req_valid, dmi_req_op, dmi_req_addr, dmi_req_data},
                      {1'b1, rop, ra, rd});
            end else begin
                check($sformatf("rnd%0d valid", it), dmi_req_valid, 64'(m_st == 1));
            end
            if (m_st == 1 && $urandom_range(0, 3) != 0) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                pulse_ready();
                m_st = 2;
            end
            if (m_st == 2 && $urandom_range(0, 3) != 0) begin
                rd = $urandom;
                er = ($urandom_range(0, 3) == 0);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                pulse_resp(rd, er);
                m_data = rd;
                if (er && m_stick < 2'd2) m_stick = 2'd2;
                m_st = 0;
            end
            if (m_stick != 2'd0 && $urandom_range(0, 2) == 0) begin
                scan_ir(5'h10, icap);
                scan_dr(32, 64'h0001_0000, o);
                check($sformatf("rnd%0d dtmcs", it), o, 64'h1061 | (64'(m_stick) << 10));
                m_stick = 2'd0;
                scan_ir(5'h11, icap);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
